// File: rtl/uart_buf_pkg.sv
// Shared constants for the UART byte buffer: register map, status bit
// positions and the transmit FSM encoding.
package uart_buf_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_TX_OVR   = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_TX_STALL = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_CHECK = 2'd2,
    S_BUSY  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_buf_sync_fifo.sv
// Single-clock FIFO with a combinational head. Fullness and emptiness are
// judged from the registered count, so a push into a full FIFO is refused.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_buf.sv
// Byte buffer between the CPU bus and the auto-baud UART: bus decode,
// sticky status flags, RX/TX FIFOs and the handshaking TX FSM.
module uart_buf
  import uart_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int RETRY_MAX  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       addr,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic [7:0] od,
  output logic       dox,
  input  logic       wip,
  input  logic [7:0] id,
  input  logic       dix
);

  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  tx_state_t state, state_nxt;
  logic [RW-1:0]       retry;
  logic                rx_ovr, tx_ovr, tx_stall;
  logic                wr_data, wr_stat, rd_data, rd_stat;
  logic [7:0]          rx_dout, tx_dout, status;
  logic                rx_full, rx_empty, tx_full, tx_empty;
  logic [DEPTH_LOG2:0] rx_count, tx_count, rx_count_nxt;
  logic                rx_push_ok, rx_pop_ok;
  logic                od_load, tx_pop, retry_inc, retry_clr, stall_set;
  logic                rx_ovr_nxt, tx_ovr_nxt, stall_nxt;

  assign wr_data = sel && we && (addr == ADDR_DATA);
  assign wr_stat = sel && we && (addr == ADDR_STAT);
  assign rd_data = sel && re && (addr == ADDR_DATA);
  assign rd_stat = sel && re && (addr == ADDR_STAT);

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(dix), .din(id), .pop(rd_data),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_data), .din(wdata), .pop(tx_pop),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  always_comb begin
    status              = '0;
    status[ST_RX_AVAIL] = !rx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_OVR]   = rx_ovr;
    status[ST_TX_OVR]   = tx_ovr;
    status[ST_TX_BUSY]  = (state != S_IDLE) || (tx_count != '0);
    status[ST_TX_STALL] = tx_stall;
  end

  // Next-state flags feed both the sticky registers and the registered irq.
  assign rx_push_ok   = dix && !rx_full;
  assign rx_pop_ok    = rd_data && !rx_empty;
  assign rx_count_nxt = rx_count + {{DEPTH_LOG2{1'b0}}, rx_push_ok}
                                 - {{DEPTH_LOG2{1'b0}}, rx_pop_ok};
  assign rx_ovr_nxt = (dix && rx_full) || (rx_ovr && !(wr_stat && wdata[ST_RX_OVR]));
  assign tx_ovr_nxt = (wr_data && tx_full) || (tx_ovr && !(wr_stat && wdata[ST_TX_OVR]));
  assign stall_set  = retry_inc && ((retry == RETRY_LIM) || ((retry + 1'b1) == RETRY_LIM));
  assign stall_nxt  = stall_set || (tx_stall && !(wr_stat && wdata[ST_TX_STALL]));

  always_comb begin
    state_nxt = state;
    dox       = 1'b0;
    od_load   = 1'b0;
    tx_pop    = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (!tx_empty && !wip) begin
          od_load   = 1'b1;
          state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        dox       = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // A UART that is not yet baud-locked ignores dox; keep the byte and retry.
        if (wip) begin
          tx_pop    = 1'b1;
          retry_clr = 1'b1;
          state_nxt = S_BUSY;
        end else begin
          retry_inc = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (!wip) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      retry    <= '0;
      rx_ovr   <= 1'b0;
      tx_ovr   <= 1'b0;
      tx_stall <= 1'b0;
      irq      <= 1'b0;
      rdata    <= '0;
      od       <= '0;
    end else begin
      state    <= state_nxt;
      rx_ovr   <= rx_ovr_nxt;
      tx_ovr   <= tx_ovr_nxt;
      tx_stall <= stall_nxt;
      irq      <= (rx_count_nxt != '0) || rx_ovr_nxt || tx_ovr_nxt;
      if (retry_clr || (wr_stat && wdata[ST_TX_STALL])) retry <= '0;
      else if (retry_inc && (retry != RETRY_LIM))       retry <= retry + 1'b1;
      if (od_load) od <= tx_dout;
      if (rd_data)      rdata <= rx_empty ? 8'h00 : rx_dout;
      else if (rd_stat) rdata <= status;
    end
  end

endmodule

// File: tb/tb_uart_buf.sv
// Scoreboard bench for uart_buf with a simple auto-baud UART model that
// can be locked, unlocked, or forced busy.
module tb_uart_buf;

  localparam int FRAME = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0, addr = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0] wdata = '0, id = '0;
  logic       dix = 1'b0;
  logic [7:0] rdata, od;
  logic       irq, dox, wip;
  logic       hold_wip = 1'b0, frame_wip = 1'b0, locked = 1'b1;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_dox = 0, attempts = 0, tx_sends = 0, dox_total = 0, frame_left = 0;

  assign wip = hold_wip | frame_wip;

  uart_buf #(.DEPTH_LOG2(4), .RETRY_MAX(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .irq(irq), .od(od), .dox(dox), .wip(wip),
    .id(id), .dix(dix)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART model and TX scoreboard: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (frame_left > 0) begin
      frame_left--;
      if (frame_left == 0) frame_wip = 1'b0;
    end
    if (dox) begin
      dox_total++;
      chk("dox_while_wip", wip, 0);
      if (exp_tx.size() == 0) chk("spurious_dox", dox, 0);
      else if (locked) begin
        chk("od_sent", od, exp_tx.pop_front());
        tx_sends++;
        frame_wip  = 1'b1;
        frame_left = FRAME;
      end else begin
        chk("od_retry", od, exp_tx[0]);
        if (attempts > 0) chk("retry_gap", cyc - last_dox, 3);
        attempts++;
        last_dox = cyc;
      end
    end
  end

  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_push(input logic [7:0] d, input bit accepted);
    if (accepted) exp_tx.push_back(d);
    bus_wr(1'b0, d);
  endtask

  task automatic bus_rd(input logic a, output logic [7:0] d);
    @(negedge clk);
    sel = 1'b1; re = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    d = rdata;
  endtask

  task automatic rd_stat(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    bus_rd(1'b1, d);
    chk(tag, d, exp);
  endtask

  task automatic rd_data(input string tag);
    logic [7:0] d, e;
    e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'h00;
    bus_rd(1'b0, d);
    chk(tag, d, e);
  endtask

  task automatic rx_byte(input logic [7:0] d, input bit accepted);
    if (accepted) exp_rx.push_back(d);
    @(negedge clk);
    dix = 1'b1; id = d;
    @(negedge clk);
    dix = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_tx.size() != 0 || wip) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(tag, exp_tx.size(), 0);
  endtask

  initial begin
    int n;
    int snap;
    logic [7:0] d, e;

    // Reset state
    #3;
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_od", od, 8'h00);
    chk("rst_dox", dox, 0);
    chk("rst_irq", irq, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd_stat("rst_status", 8'h00);

    // Locked UART: two bytes, second only after wip falls
    cpu_push(8'h55, 1);
    cpu_push(8'hA3, 1);
    wait_drain("t1_drain");
    chk("t1_sends", tx_sends, 2);
    rd_stat("t1_status_idle", 8'h00);

    // Unlocked UART: retries every 3 cycles, stall after 4 attempts
    @(posedge clk) locked = 1'b0;
    cpu_push(8'h7E, 1);
    n = 0;
    while (attempts < 3 && n < 200) begin @(negedge clk); n++; end
    chk("t2_three_attempts", attempts, 3);
    rd_stat("t2_no_stall_yet", 8'h10);
    n = 0;
    while (attempts < 4 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rd_stat("t2_stall", 8'h30);
    snap = tx_sends;
    @(posedge clk) begin locked = 1'b1; attempts = 0; end
    wait_drain("t2_drain");
    repeat (20) @(negedge clk);
    chk("t2_sent_once", tx_sends - snap, 1);
    rd_stat("t2_stall_kept", 8'h20);
    bus_wr(1'b1, 8'h20);
    rd_stat("t2_stall_clr", 8'h00);

    // TX overrun with the UART held busy
    @(negedge clk) hold_wip = 1'b1;
    for (int i = 0; i < 16; i++) cpu_push(8'(i), 1);
    rd_stat("t3_full", 8'h12);
    chk("t3_irq_before", irq, 0);
    cpu_push(8'h10, 0);
    rd_stat("t3_ovr", 8'h1A);
    chk("t3_irq", irq, 1);
    bus_wr(1'b1, 8'h08);
    chk("t3_irq_clr", irq, 0);
    @(negedge clk) hold_wip = 1'b0;
    wait_drain("t3_drain");
    rd_stat("t3_status_idle", 8'h00);

    // RX overrun and drain
    for (int i = 0; i < 17; i++) rx_byte(8'(8'h80 + i), i < 16);
    rd_stat("t4_ovr", 8'h05);
    chk("t4_irq", irq, 1);
    for (int i = 0; i < 16; i++) rd_data("t4_rx_data");
    rd_stat("t4_avail_low", 8'h04);
    rd_data("t4_empty_read");
    bus_wr(1'b1, 8'h04);
    chk("t4_irq_clr", irq, 0);
    rd_stat("t4_clr", 8'h00);

    // Simultaneous push and pop at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) rx_byte(8'(8'hC0 + i), 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = 8'(8'h20 + i);
      exp_rx.push_back(e);
      dix = 1'b1; id = e; sel = 1'b1; re = 1'b1; addr = 1'b0;
      @(negedge clk);
      dix = 1'b0; sel = 1'b0; re = 1'b0;
      d = rdata;
      chk("t5_pushpop", d, exp_rx.pop_front());
    end
    chk("t5_model_count", exp_rx.size(), 5);
    for (int i = 0; i < 5; i++) rd_data("t5_tail");
    rd_data("t5_empty");

    // Reset during PULSE with bytes queued
    @(posedge clk) locked = 1'b0;
    @(negedge clk) hold_wip = 1'b1;
    cpu_push(8'h11, 1);
    cpu_push(8'h22, 1);
    cpu_push(8'h33, 1);
    @(negedge clk) hold_wip = 1'b0;
    n = 0;
    while (!dox && n < 40) begin @(negedge clk); n++; end
    chk("t6_dox_seen", dox, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_dox_reset", dox, 0);
    chk("t6_od_reset", od, 8'h00);
    chk("t6_irq_reset", irq, 0);
    exp_tx.delete();
    attempts = 0;
    @(negedge clk) reset = 1'b0;
    snap = dox_total;
    repeat (30) @(negedge clk);
    chk("t6_no_dox", dox_total - snap, 0);
    rd_stat("t6_status", 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_buf.md
Name: uart_buf

Overview:
- Byte-buffering stage between the b16 I/O bus and the auto-baud UART core.
- TX: CPU writes go into a TX FIFO, which is drained into the UART one byte per frame using od/dox/wip.
- RX: each dix pulse captures id into an RX FIFO that the CPU reads.
- Decouples CPU timing from serial frame timing; flags overruns and raises an interrupt request.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (depth = 16 bytes per direction)
RETRY_MAX, 4, consecutive unacknowledged dox attempts before the tx_stall status bit is set

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
sel  input  1  bus select for this block
addr  input  1  0 = data, 1 = status/control
we  input  1  write strobe, qualified by sel
re  input  1  read strobe, qualified by sel
wdata  input  8  write data
rdata  output  8  registered read data, valid the cycle after re
irq  output  1  rx_avail | rx_ovr | tx_ovr
od  output  8  byte to UART, held stable from the dox cycle onward
dox  output  1  one-cycle send request to UART
wip  input  1  UART transmit in progress
id  input  8  received byte from UART
dix  input  1  one-cycle received-byte strobe from UART

Behaviour:
- Reset (async, active-high): both FIFOs empty, pointers 0, all sticky flags 0, TX FSM in IDLE, rdata=0, dox=0, od=0, irq=0. Reset mid-frame does not touch the UART; any frame already in the UART completes on its own.
- Status byte, bits 7..0: {2'b0, tx_stall, tx_busy, tx_ovr, rx_ovr, tx_full, rx_avail}.
  - tx_busy = FSM != IDLE or TX FIFO non-empty.
- Bus write, addr 0: push wdata to TX FIFO. If TX is full, drop the byte and set tx_ovr.
- Bus write, addr 1: bit2=1 clears rx_ovr; bit3=1 clears tx_ovr; bit5=1 clears tx_stall and the retry counter.
- Bus read, addr 0: rdata <= RX head and pop. If RX is empty, rdata <= 0x00 and no pop.
- Bus read, addr 1: rdata <= status.
- Without re: rdata holds its last value.
- RX capture: on dix=1, push id.
  - If RX is full, drop the byte and set rx_ovr.
  - If RX is full and a CPU pop happens the same cycle, still drop; fullness is judged at cycle start.
- FIFO rules, both directions:
  - Push is accepted only if not full at cycle start; pop only if not empty.
  - Simultaneous push and pop: count unchanged, data order preserved.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth; count is DEPTH_LOG2+1 bits.
  - A pushed byte is poppable the next cycle.
- Overrun flags: a set event in the same cycle as a clear wins (flag stays 1).
- TX FSM, states IDLE, PULSE, CHECK, BUSY:
  - IDLE: if TX non-empty and wip=0 → PULSE; od <= head (not popped).
  - PULSE: dox=1 for exactly one cycle → CHECK.
  - CHECK: the UART must raise wip the cycle after dox.
    - If wip=1: pop head, clear retry count → BUSY.
    - If wip=0 (UART not yet baud-locked, so dox is ignored): keep head, increment retry count (saturating) → IDLE. When the count reaches RETRY_MAX, set tx_stall.
    - Retries continue indefinitely; a byte is never lost.
  - BUSY: wait for wip=0 → IDLE.
- Throughput: a new dox issues the cycle after wip falls + 1 (IDLE→PULSE).
- dox is never asserted while wip=1 or outside PULSE.
- irq is registered, updated every cycle from next-state flags.

Decomposition:
- Package uart_buf_pkg:
  - register address constants ADDR_DATA=0, ADDR_STAT=1
  - status bit index constants
  - TX FSM state encoding (2-bit enum)
- Sub-module sync_fifo (params WIDTH=8, DEPTH_LOG2), instantiated twice.
  - Ports: clk, reset, push, din, pop, dout, full, empty, count.
  - dout shows the head combinationally.
- Top level holds bus decode, flags, TX FSM and retry counter.

Test Plan:
- UART model locked; CPU writes 0x55, 0xA3 → dox pulses twice with od=0x55 then 0xA3. Second dox comes only after wip falls. tx_busy clears after the last frame.
- UART model unlocked (ignores dox) with one byte 0x7E queued → dox repeats every 3 cycles and tx_stall sets after 4 attempts. Lock the model: 0x7E is sent exactly once; write 0x20 to status clears tx_stall.
- 17 CPU writes 0x00..0x10 with wip held high → tx_full=1 after 16; 0x10 dropped; tx_ovr=1, irq=1. Release wip → bytes 0x00..0x0F emitted in order.
- 17 dix pulses id=0x80..0x90, no reads → rx_ovr=1 and 0x90 dropped. Then 16 reads return 0x80..0x8F, rx_avail falls after the 16th, a 17th read returns 0x00.
- dix push and CPU pop in the same cycle at count=5 → count stays 5; order intact across pointer wrap (push/pop 40 bytes).
- Assert reset during PULSE with 3 bytes queued → dox=0 immediately; status reads 0x00; no further dox without new writes.
